// File: rtl/pu_or1k_pic_pkg.sv
// Shared types and helpers for the OR1K programmable interrupt controller.
// Provides register widths, TTMR field positions and the lowest-set-bit encoder.
package pu_or1k_pic_pkg;

   localparam int IRQ_ID_W    = 5;
   localparam int PIC_REG_W   = 32;
   localparam int TTMR_IE_BIT = 29;
   localparam int TTMR_IP_BIT = 28;

   typedef enum logic [1:0] {
      PIC_SEL_NONE,
      PIC_SEL_PICMR,
      PIC_SEL_PICSR
   } pic_sel_e;

   // Lowest index wins; an all-zero vector encodes as 0.
   function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [PIC_REG_W-1:0] v);
      logic [IRQ_ID_W-1:0] id;
      logic                found;
      id    = '0;
      found = 1'b0;
      for (int i = 0; i < PIC_REG_W; i++) begin
         if (v[i] && !found) begin
            id    = IRQ_ID_W'(i);
            found = 1'b1;
         end
      end
      return id;
   endfunction

endpackage

// File: rtl/pu_or1k_defines.sv
// OR1K SPR address map shared by the processing-unit blocks.
// Only the PIC registers are needed here; offsets are the low 11 bits of an SPR address.
`ifndef PU_OR1K_DEFINES_SV
`define PU_OR1K_DEFINES_SV

`define SPR_OFFSET(x) (x[10:0])
`define OR1K_SPR_PICMR_ADDR 16'h4800
`define OR1K_SPR_PICSR_ADDR 16'h4802

`endif

// File: rtl/pu_or1k_sync.sv
// Multi-flop synchroniser for a vector of asynchronous level inputs.
// Each bit is synchronised independently; STAGES must be at least 2.
module pu_or1k_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stage <= '0;
      end else begin
         r_stage <= {r_stage[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/pu_or1k_pic.sv
// OR1K programmable interrupt controller: PICMR/PICSR on the SPR bus, tick and external requests.
// Define PU_OR1K_PIC_EDGE_EN for rising-edge, write-1-to-clear lines; default is level mode.
`ifndef PU_OR1K_DEFINES_SV
`include "pu_or1k_defines.sv"
`endif

module pu_or1k_pic
   import pu_or1k_pic_pkg::*;
#(
   parameter int          NUM_IRQ     = 32,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] PICMR_RST   = 32'h0000_0003
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IRQ-1:0]  irq_i,
   input  logic [31:0]         spr_ttmr_i,
   input  logic                spr_access_i,
   input  logic                spr_we_i,
   input  logic [15:0]         spr_addr_i,
   input  logic [31:0]         spr_dat_i,
   output logic                spr_bus_ack,
   output logic [31:0]         spr_dat_o,
   output logic [31:0]         spr_picmr_o,
   output logic [31:0]         spr_picsr_o,
   output logic                tick_int_o,
   output logic                pic_int_o,
   output logic [IRQ_ID_W-1:0] irq_id_o
);

   localparam logic [15:0] PICMR_ADDR = `OR1K_SPR_PICMR_ADDR;
   localparam logic [15:0] PICSR_ADDR = `OR1K_SPR_PICSR_ADDR;
   localparam logic [31:0] IRQ_MASK   = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'h1 << NUM_IRQ) - 32'h1);

   logic [10:0]        w_offset;
   pic_sel_e           w_sel;
   logic               w_picmr_we;
   logic [NUM_IRQ-1:0] w_sync;
   logic [31:0]        w_sync_ext;
   logic [31:0]        w_picsr_next;
   logic [31:0]        r_picmr;
   logic [31:0]        r_picsr;
   logic               w_unused;

   assign w_offset = `SPR_OFFSET(spr_addr_i);

   always_comb begin
      w_sel = PIC_SEL_NONE;
      if (w_offset == `SPR_OFFSET(PICMR_ADDR)) begin
         w_sel = PIC_SEL_PICMR;
      end else if (w_offset == `SPR_OFFSET(PICSR_ADDR)) begin
         w_sel = PIC_SEL_PICSR;
      end
   end

   assign w_picmr_we  = spr_access_i & spr_we_i & (w_sel == PIC_SEL_PICMR);
   assign spr_bus_ack = spr_access_i;

   always_comb begin
      spr_dat_o = '0;
      case (w_sel)
         PIC_SEL_PICMR: spr_dat_o = r_picmr;
         PIC_SEL_PICSR: spr_dat_o = r_picsr;
         default:       spr_dat_o = '0;
      endcase
   end

   pu_or1k_sync #(
      .WIDTH  (NUM_IRQ),
      .STAGES (SYNC_STAGES)
   ) u_irq_sync (
      .clk (clk),
      .rst (rst),
      .i_d (irq_i),
      .o_q (w_sync)
   );

   // Widen to the 32-bit register view; lines beyond NUM_IRQ never assert.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_sync_ext
         if (gi < NUM_IRQ) begin : g_line
            assign w_sync_ext[gi] = w_sync[gi];
         end else begin : g_none
            assign w_sync_ext[gi] = 1'b0;
         end
      end
   endgenerate

`ifdef PU_OR1K_PIC_EDGE_EN
   logic        w_picsr_we;
   logic [31:0] w_w1c;
   logic [31:0] r_sync_q;
   logic [31:0] r_rise;

   assign w_picsr_we = spr_access_i & spr_we_i & (w_sel == PIC_SEL_PICSR);
   assign w_w1c      = w_picsr_we ? spr_dat_i : 32'h0;

   // Registered edge detect; OR-ing the new edge after the clear lets a coincident edge win.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync_q <= '0;
         r_rise   <= '0;
      end else begin
         r_sync_q <= w_sync_ext;
         r_rise   <= w_sync_ext & ~r_sync_q;
      end
   end

   assign w_picsr_next = (r_picsr & ~w_w1c) | (r_rise & r_picmr);
`else
   assign w_picsr_next = w_sync_ext & r_picmr;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_picmr <= PICMR_RST & IRQ_MASK;
         r_picsr <= '0;
      end else begin
         if (w_picmr_we) begin
            r_picmr <= spr_dat_i & IRQ_MASK;
         end
         r_picsr <= w_picsr_next;
      end
   end

   assign spr_picmr_o = r_picmr;
   assign spr_picsr_o = r_picsr;
   assign pic_int_o   = |r_picsr;
   assign irq_id_o    = lowest_set(r_picsr);
   assign tick_int_o  = spr_ttmr_i[TTMR_IE_BIT] & spr_ttmr_i[TTMR_IP_BIT];

   assign w_unused = ^{spr_addr_i[15:11], spr_ttmr_i[31:30], spr_ttmr_i[27:0]};

endmodule

// File: tb/tb_pu_or1k_pic.sv
// Self-checking bench for pu_or1k_pic: reset, level latency, mask/priority table, tick, mid-op reset.
// Edge-mode sequences run when PU_OR1K_PIC_EDGE_EN is defined.
module tb_pu_or1k_pic;

   localparam int SYNC = 2;
`ifdef PU_OR1K_PIC_EDGE_EN
   localparam int LAT = SYNC + 1;
`else
   localparam int LAT = SYNC;
`endif
   localparam logic [15:0] A_PICMR = 16'h4800;
   localparam logic [15:0] A_PICSR = 16'h4802;
   localparam logic [15:0] A_NONE  = 16'h4801;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] irq_i = '0;
   logic [31:0] spr_ttmr_i = '0;
   logic        spr_access_i = 1'b0;
   logic        spr_we_i = 1'b0;
   logic [15:0] spr_addr_i = '0;
   logic [31:0] spr_dat_i = '0;
   logic        spr_bus_ack;
   logic [31:0] spr_dat_o;
   logic [31:0] spr_picmr_o;
   logic [31:0] spr_picsr_o;
   logic        tick_int_o;
   logic        pic_int_o;
   logic [4:0]  irq_id_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] irq;
      logic [31:0] picmr;
      logic [31:0] ttmr;
      logic [31:0] exp_picsr;
      logic [4:0]  exp_id;
      logic        exp_int;
      logic        exp_tick;
   } vec_t;

   typedef struct {
      logic [31:0] picsr;
      logic [31:0] picmr;
      logic [4:0]  id;
      logic        pint;
      logic        tick;
   } exp_t;

   vec_t vecs[8];
   exp_t sb_q[$];

   pu_or1k_pic #(
      .NUM_IRQ     (32),
      .SYNC_STAGES (SYNC),
      .PICMR_RST   (32'h0000_0003)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .irq_i        (irq_i),
      .spr_ttmr_i   (spr_ttmr_i),
      .spr_access_i (spr_access_i),
      .spr_we_i     (spr_we_i),
      .spr_addr_i   (spr_addr_i),
      .spr_dat_i    (spr_dat_i),
      .spr_bus_ack  (spr_bus_ack),
      .spr_dat_o    (spr_dat_o),
      .spr_picmr_o  (spr_picmr_o),
      .spr_picsr_o  (spr_picsr_o),
      .tick_int_o   (tick_int_o),
      .pic_int_o    (pic_int_o),
      .irq_id_o     (irq_id_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   task automatic spr_write(input logic [15:0] addr, input logic [31:0] data);
      spr_access_i = 1'b1;
      spr_we_i     = 1'b1;
      spr_addr_i   = addr;
      spr_dat_i    = data;
      tick();
      spr_access_i = 1'b0;
      spr_we_i     = 1'b0;
      spr_dat_i    = '0;
   endtask

   task automatic spr_read_chk(input string name, input logic [15:0] addr, input logic [31:0] exp);
      spr_access_i = 1'b1;
      spr_we_i     = 1'b0;
      spr_addr_i   = addr;
      #1;
      chk(name, spr_dat_o, exp);
      spr_access_i = 1'b0;
   endtask

   initial begin
      vecs[0] = '{32'h0000_0004, 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 5'd2,  1'b1, 1'b0};
      vecs[1] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0, 1'b0};
      vecs[2] = '{32'h0000_000A, 32'h0000_0008, 32'h0000_0000, 32'h0000_0008, 5'd3,  1'b1, 1'b0};
      vecs[3] = '{32'h0000_000A, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 5'd1,  1'b1, 1'b0};
      vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h3000_0000, 32'h8000_0000, 5'd31, 1'b1, 1'b1};
      vecs[5] = '{32'h0000_00F0, 32'h0000_0030, 32'h2000_0000, 32'h0000_0030, 5'd4,  1'b1, 1'b0};
      vecs[6] = '{32'h0000_0000, 32'h0000_0030, 32'h1000_0000, 32'h0000_0000, 5'd0,  1'b0, 1'b0};
      vecs[7] = '{32'h0000_00FF, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_00FF, 5'd0,  1'b1, 1'b1};

      // Reset held for two edges with an SPR access pending.
      rst = 1'b0;
      spr_access_i = 1'b1;
      tick();
      tick();
      chk("rst_picmr", spr_picmr_o, 32'h3);
      chk("rst_picsr", spr_picsr_o, 32'h0);
      chk("rst_pic_int", {31'b0, pic_int_o}, 32'h0);
      chk("rst_irq_id", {27'b0, irq_id_o}, 32'h0);
      chk("ack_high", {31'b0, spr_bus_ack}, 32'h1);
      spr_access_i = 1'b0;
      #1;
      chk("ack_low", {31'b0, spr_bus_ack}, 32'h0);
      rst = 1'b1;

      // Exact latency from an irq rise to PICSR.
      spr_write(A_PICMR, 32'h4);
      repeat (4) tick();
      chk("lat_idle", spr_picsr_o, 32'h0);
      irq_i = 32'h4;
      repeat (LAT) tick();
      chk("lat_early", spr_picsr_o, 32'h0);
      tick();
      chk("lat_set", spr_picsr_o, 32'h4);
      chk("lat_id", {27'b0, irq_id_o}, 32'd2);
      chk("lat_int", {31'b0, pic_int_o}, 32'h1);

`ifdef PU_OR1K_PIC_EDGE_EN
      // Held line: a W1C clears and no new edge re-sets it.
      spr_write(A_PICSR, 32'h4);
      chk("e_w1c_held", spr_picsr_o, 32'h0);
      irq_i = 32'h0;
      spr_write(A_PICMR, 32'h20);
      repeat (4) tick();
      irq_i = 32'h20;
      tick();
      irq_i = 32'h0;
      repeat (5) tick();
      chk("e_pulse_latched", spr_picsr_o, 32'h20);
      chk("e_pulse_id", {27'b0, irq_id_o}, 32'd5);
      spr_write(A_PICSR, 32'h20);
      chk("e_w1c", spr_picsr_o, 32'h0);
      // New edge lands on the same edge as a W1C: set wins.
      irq_i = 32'h20;
      tick();
      irq_i = 32'h0;
      tick();
      tick();
      spr_write(A_PICSR, 32'h20);
      chk("e_set_wins", spr_picsr_o, 32'h20);
      spr_write(A_PICSR, 32'h20);
      chk("e_clear_again", spr_picsr_o, 32'h0);
      // Edge while masked is dropped.
      spr_write(A_PICMR, 32'h0);
      irq_i = 32'h20;
      tick();
      irq_i = 32'h0;
      repeat (5) tick();
      spr_write(A_PICMR, 32'h20);
      repeat (3) tick();
      chk("e_masked_drop", spr_picsr_o, 32'h0);
`else
      // Software writes to PICSR have no effect in level mode.
      spr_write(A_PICSR, 32'hFFFF_FFFF);
      chk("l_picsr_wr_ignored", spr_picsr_o, 32'h4);
      // Clearing the mask drops the bit one cycle after the write.
      spr_write(A_PICMR, 32'h0);
      chk("l_mask_same", spr_picsr_o, 32'h4);
      tick();
      chk("l_mask_drop", spr_picsr_o, 32'h0);
      irq_i = 32'h0;

      // Table of steady-state vectors; expectations queued on drive, popped after settling.
      for (int i = 0; i < 8; i++) begin
         exp_t e;
         irq_i      = vecs[i].irq;
         spr_ttmr_i = vecs[i].ttmr;
         e.picsr = vecs[i].exp_picsr;
         e.picmr = vecs[i].picmr;
         e.id    = vecs[i].exp_id;
         e.pint  = vecs[i].exp_int;
         e.tick  = vecs[i].exp_tick;
         sb_q.push_back(e);
         spr_write(A_PICMR, vecs[i].picmr);
         repeat (SYNC + 2) tick();
         e = sb_q.pop_front();
         chk($sformatf("v%0d_picsr", i), spr_picsr_o, e.picsr);
         chk($sformatf("v%0d_irq_id", i), {27'b0, irq_id_o}, {27'b0, e.id});
         chk($sformatf("v%0d_pic_int", i), {31'b0, pic_int_o}, {31'b0, e.pint});
         chk($sformatf("v%0d_tick", i), {31'b0, tick_int_o}, {31'b0, e.tick});
         spr_read_chk($sformatf("v%0d_rd_picmr", i), A_PICMR, e.picmr);
         spr_read_chk($sformatf("v%0d_rd_picsr", i), A_PICSR, e.picsr);
      end
`endif

      // Mid-operation reset for one edge discards everything.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_rst_picsr", spr_picsr_o, 32'h0);
      chk("mid_rst_picmr", spr_picmr_o, 32'h3);
      chk("mid_rst_int", {31'b0, pic_int_o}, 32'h0);
      chk("mid_rst_id", {27'b0, irq_id_o}, 32'h0);
      spr_read_chk("rd_unmapped", A_NONE, 32'h0);
      spr_read_chk("rd_picmr_rst", A_PICMR, 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
